// File: rtl/ru_result_collector.sv
// Frame buffer for RU pow2 results: stores one frame, sums it with saturation, then replays it.
// Optional RU_COLLECT_MAX_EN adds a per-frame signed max of i_in0 on o_max.
module ru_result_collector #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int SUM_W  = 24
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_valid,
   input  logic [DATA_W-1:0]          i_in0,
   input  logic [DATA_W-1:0]          i_in1,
   input  logic                       i_last,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [DATA_W-1:0]          o_data,
   output logic                       o_last,
   output logic [SUM_W-1:0]           o_sum,
   output logic                       o_sum_vld,
   output logic [$clog2(DEPTH):0]     o_cnt,
   output logic                       o_err,
   output logic [DATA_W-1:0]          o_max
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {FILL, DRAIN} state_t;

   state_t              state_reg;
   logic [DATA_W-1:0]   mem_reg [DEPTH];
   logic [CW-1:0]       cnt_reg;
   logic [AW-1:0]       rd_ptr_reg;
   logic [SUM_W-1:0]    sum_reg;
   logic [SUM_W-1:0]    o_sum_reg;
   logic                o_sum_vld_reg;
   logic                o_valid_reg;
   logic                o_last_reg;
   logic [DATA_W-1:0]   o_data_reg;
   logic                o_err_reg;

   logic                full;
   logic                accept;
   logic                drop;
   logic                close;
   logic                xfer;
   logic [CW-1:0]       cnt_next;
   logic [AW-1:0]       rd_next;
   logic [SUM_W:0]      sum_wide;
   logic [SUM_W-1:0]    sum_sat;
   logic [SUM_W-1:0]    sum_next;

   always_comb begin
      full     = (cnt_reg == CW'(DEPTH));
      accept   = i_en && (state_reg == FILL) && i_valid && !full;
      drop     = i_en && i_valid && ((state_reg == DRAIN) || full);
      close    = i_en && (state_reg == FILL) && i_valid && i_last;
      xfer     = i_en && (state_reg == DRAIN) && i_ready;
      cnt_next = cnt_reg + {{(CW-1){1'b0}}, accept};
      rd_next  = rd_ptr_reg + AW'(1);
      // One guard bit: a disagreement between the top two bits means the add overflowed.
      sum_wide = {sum_reg[SUM_W-1], sum_reg}
               + {{(SUM_W+1-DATA_W){i_in1[DATA_W-1]}}, i_in1};
      sum_sat  = sum_wide[SUM_W-1:0];
      if (sum_wide[SUM_W] != sum_wide[SUM_W-1])
         sum_sat = sum_wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}}
                                   : {1'b0, {(SUM_W-1){1'b1}}};
      sum_next = accept ? sum_sat : sum_reg;
   end

   always_ff @(posedge i_clk) begin
      if (accept)
         mem_reg[cnt_reg[AW-1:0]] <= i_in1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg     <= FILL;
         cnt_reg       <= '0;
         rd_ptr_reg    <= '0;
         sum_reg       <= '0;
         o_sum_reg     <= '0;
         o_sum_vld_reg <= 1'b0;
         o_valid_reg   <= 1'b0;
         o_last_reg    <= 1'b0;
         o_data_reg    <= '0;
         o_err_reg     <= 1'b0;
      end else if (!i_en) begin
         o_sum_vld_reg <= 1'b0;
      end else begin
         o_sum_vld_reg <= 1'b0;
         if (drop)
            o_err_reg <= 1'b1;
         case (state_reg)
            FILL: begin
               cnt_reg <= cnt_next;
               sum_reg <= sum_next;
               if (close) begin
                  state_reg     <= DRAIN;
                  o_sum_reg     <= sum_next;
                  o_sum_vld_reg <= 1'b1;
                  o_valid_reg   <= 1'b1;
                  rd_ptr_reg    <= '0;
                  o_last_reg    <= (cnt_next == CW'(1));
                  // Single-element frame: entry 0 is being written this very edge.
                  o_data_reg    <= (accept && cnt_reg == '0) ? i_in1 : mem_reg[0];
               end
            end
            DRAIN: begin
               if (xfer) begin
                  if (o_last_reg) begin
                     state_reg   <= FILL;
                     cnt_reg     <= '0;
                     rd_ptr_reg  <= '0;
                     sum_reg     <= '0;
                     o_valid_reg <= 1'b0;
                     o_last_reg  <= 1'b0;
                  end else begin
                     rd_ptr_reg <= rd_next;
                     o_data_reg <= mem_reg[rd_next];
                     o_last_reg <= ({1'b0, rd_next} == cnt_reg - CW'(1));
                  end
               end
            end
            default: state_reg <= FILL;
         endcase
      end
   end

`ifdef RU_COLLECT_MAX_EN
   localparam logic [DATA_W-1:0] MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};
   logic [DATA_W-1:0] max_run_reg;
   logic [DATA_W-1:0] max_run_next;
   logic [DATA_W-1:0] o_max_reg;

   always_comb begin
      max_run_next = max_run_reg;
      if (accept && ($signed(i_in0) > $signed(max_run_reg)))
         max_run_next = i_in0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         max_run_reg <= MAX_INIT;
         o_max_reg   <= MAX_INIT;
      end else if (i_en) begin
         if (state_reg == FILL) begin
            max_run_reg <= max_run_next;
            if (close)
               o_max_reg <= max_run_next;
         end else if (xfer && o_last_reg) begin
            max_run_reg <= MAX_INIT;
         end
      end
   end

   assign o_max = o_max_reg;
`else
   logic unused_in0;
   assign unused_in0 = ^i_in0;
   assign o_max      = '0;
`endif

   assign o_valid   = o_valid_reg;
   assign o_data    = o_data_reg;
   assign o_last    = o_last_reg;
   assign o_sum     = o_sum_reg;
   assign o_sum_vld = o_sum_vld_reg;
   assign o_cnt     = cnt_reg;
   assign o_err     = o_err_reg;
endmodule
